// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the pipeline MEM stage and a host port.
// The core has priority and the host is guaranteed a slot by a starvation
// counter. One access is in flight at a time. Every output is forced to 0
// while reset is low.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_funct3,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [2:0]        host_funct3,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CORE_RD = 2'd1;
    localparam logic [1:0] HOST_RD = 2'd2;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state, stateNext;
    logic [CNT_W-1:0] starveCnt;
    logic             hostWin;

    // Arbitration, port muxing and response routing for the current cycle
    always_comb begin
        stateNext   = state;
        hostWin     = 1'b0;
        core_rdata  = '0;
        core_rvalid = 1'b0;
        core_stall  = 1'b0;
        host_gnt    = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_funct3  = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    hostWin = host_req & (~core_req | (starveCnt >= LIMIT));
                    if (hostWin) begin
                        mem_en     = 1'b1;
                        mem_we     = host_we;
                        mem_addr   = host_addr;
                        mem_wdata  = host_wdata;
                        mem_funct3 = host_funct3;
                        host_gnt   = 1'b1;
                        core_stall = core_req;
                        stateNext  = host_we ? IDLE : HOST_RD;
                    end else if (core_req) begin
                        mem_en     = 1'b1;
                        mem_we     = core_we;
                        mem_addr   = core_addr;
                        mem_wdata  = core_wdata;
                        mem_funct3 = core_funct3;
                        core_stall = ~core_we;
                        stateNext  = core_we ? IDLE : CORE_RD;
                    end
                end
                CORE_RD: begin
                    // Pipeline advances at this edge, so the load is not re-issued
                    core_rvalid = 1'b1;
                    core_rdata  = mem_rdata;
                    stateNext   = IDLE;
                end
                HOST_RD: begin
                    host_rvalid = 1'b1;
                    host_rdata  = mem_rdata;
                    core_stall  = core_req;
                    stateNext   = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // State register and saturating count of consecutive denied host cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= '0;
        end else begin
            state <= stateNext;
            if (!host_req || host_gnt)
                starveCnt <= '0;
            else if (starveCnt < LIMIT)
                starveCnt <= starveCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by randomized
// traffic, all compared against a transaction-level model with a word memory.
module tb_dmem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_rvalid, core_stall;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [2:0]  core_funct3;
    logic        host_req, host_we, host_gnt, host_rvalid;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic [2:0]  host_funct3;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_funct3(host_funct3),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    // 16-word synchronous-read memory behind the port
    logic [31:0] memArr [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) memArr[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= memArr[mem_addr[5:2]];
        end
    end

    int checks = 0;
    int failures = 0;

    // Model: who owns the outstanding read (0 none, 1 core, 2 host), its word,
    // consecutive denied host cycles, and the expected memory image.
    int          pend = 0;
    int          pendIdx = 0;
    int          starve = 0;
    logic [31:0] refMem [16];
    logic        lastGnt, lastStall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already driven after a negedge
    task automatic step();
        logic eEn, eWe, eGnt, eStall, eCrv, eHrv, hw;
        logic [31:0] eAddr, eWdata, eCrd, eHrd;
        logic [2:0]  eF3;
        eEn = 0; eWe = 0; eGnt = 0; eStall = 0; eCrv = 0; eHrv = 0;
        eAddr = 0; eWdata = 0; eCrd = 0; eHrd = 0; eF3 = 0;
        #2;
        if (reset) begin
            if (pend == 1) begin
                eCrv = 1; eCrd = refMem[pendIdx];
            end else if (pend == 2) begin
                eHrv = 1; eHrd = refMem[pendIdx]; eStall = core_req;
            end else begin
                hw = host_req && (!core_req || starve >= LIM);
                if (hw) begin
                    eGnt = 1; eEn = 1; eWe = host_we; eAddr = host_addr;
                    eWdata = host_wdata; eF3 = host_funct3; eStall = core_req;
                end else if (core_req) begin
                    eEn = 1; eWe = core_we; eAddr = core_addr;
                    eWdata = core_wdata; eF3 = core_funct3; eStall = !core_we;
                end
            end
        end
        chk("mem_en", {31'b0, mem_en}, {31'b0, eEn});
        chk("mem_we", {31'b0, mem_we}, {31'b0, eWe});
        chk("mem_addr", mem_addr, eAddr);
        chk("mem_wdata", mem_wdata, eWdata);
        chk("mem_funct3", {29'b0, mem_funct3}, {29'b0, eF3});
        chk("host_gnt", {31'b0, host_gnt}, {31'b0, eGnt});
        chk("core_stall", {31'b0, core_stall}, {31'b0, eStall});
        chk("core_rvalid", {31'b0, core_rvalid}, {31'b0, eCrv});
        chk("core_rdata", core_rdata, eCrd);
        chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, eHrv});
        chk("host_rdata", host_rdata, eHrd);
        lastGnt = eGnt;
        lastStall = eStall;
        @(posedge clk);
        if (!reset) begin
            pend = 0; starve = 0;
        end else begin
            if (pend != 0) pend = 0;
            else if (eEn) begin
                if (eWe) refMem[eAddr[5:2]] = eWdata;
                else begin pend = eGnt ? 2 : 1; pendIdx = int'(eAddr[5:2]); end
            end
            if (!host_req || eGnt) starve = 0;
            else if (starve < LIM) starve++;
        end
        @(negedge clk);
    endtask

    task automatic setCore(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d; core_funct3 = 3'b010;
    endtask

    task automatic setHost(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        host_req = r; host_we = w; host_addr = a; host_wdata = d; host_funct3 = 3'b010;
    endtask

    int denied;

    initial begin
        for (int i = 0; i < 16; i++) refMem[i] = 32'h0;
        reset = 0;
        setCore(1, 0, 32'h4, 32'h0);
        setHost(1, 0, 32'h8, 32'h0);
        @(negedge clk);
        // Reset held with both requesters active
        for (int i = 0; i < 3; i++) step();
        reset = 1;
        setHost(1, 1, 32'h8, 32'h11);
        #2;
        chk("t1_core_first", {30'b0, mem_en, host_gnt}, 32'h2);
        step();
        step();
        setHost(0, 0, 0, 0);
        setCore(0, 0, 0, 0);
        step();
        // Preload every word with core stores
        for (int i = 0; i < 16; i++) begin
            setCore(1, 1, i * 4, $urandom);
            step();
        end
        // Core store 0x10
        setCore(1, 1, 32'h10, 32'hDEADBEEF);
        #2;
        chk("t2_store", {29'b0, mem_en, mem_we, core_stall}, 32'h6);
        step();
        // Core load 0x10
        setCore(1, 0, 32'h10, 0);
        step();
        chk("t3_stall", {31'b0, lastStall}, 32'h1);
        #2;
        chk("t3_rdata", core_rdata, 32'hDEADBEEF);
        chk("t3_en", {30'b0, core_rvalid, mem_en}, 32'h2);
        step();
        // Back-to-back core loads against a waiting host write
        setHost(1, 1, 32'h20, 32'hCAFE0001);
        denied = 0;
        for (int i = 0; i < 20 && !lastGnt; i++) begin
            setCore(1, 0, 32'h4 * (i % 4), 0);
            if (pend == 1) core_addr = core_addr + 32'h4;
            step();
            if (!lastGnt) denied++;
        end
        chk("t4_gnt_seen", {31'b0, lastGnt}, 32'h1);
        chk("t4_denied", denied, LIM);
        chk("t4_stall_at_gnt", {31'b0, lastStall}, 32'h1);
        setHost(0, 0, 0, 0);
        step();
        step();
        setCore(0, 0, 0, 0);
        step();
        // Host read with core idle, core load arriving during the read data cycle
        setHost(1, 0, 32'h10, 0);
        step();
        chk("t5_gnt", {31'b0, lastGnt}, 32'h1);
        setHost(0, 0, 0, 0);
        setCore(1, 0, 32'h20, 0);
        #2;
        chk("t5_hrdata", host_rdata, 32'hDEADBEEF);
        chk("t5_stall", {30'b0, host_rvalid, core_stall}, 32'h3);
        step();
        #2;
        chk("t5_issue", {30'b0, mem_en, mem_we}, 32'h2);
        step();
        step();
        setCore(0, 0, 0, 0);
        step();
        // Reset during the core load data cycle
        setCore(1, 0, 32'h10, 0);
        step();
        reset = 0;
        step();
        reset = 1;
        #2;
        chk("t6_reissue", {30'b0, mem_en, core_rvalid}, 32'h2);
        step();
        step();
        // Randomized traffic honouring the hold rules
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 39) != 0);
            if (!lastStall)
                setCore($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                        {26'b0, 4'($urandom), 2'b00}, $urandom);
            if (!host_req || lastGnt)
                setHost($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                        {26'b0, 4'($urandom), 2'b00}, $urandom);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
